// File: rtl/qcldpc_stream_encoder.sv
// qcldpc_stream_encoder
// Streaming QC-LDPC parity encoder with run-time lifting size selection.
// Info blocks arrive one per cycle and are folded into all parity
// accumulators at once, each with its own circulant shift read from an
// external proto-matrix ROM. The finished parity blocks then drain over
// a second valid/ready port.

module qcldpc_stream_encoder #(
   parameter int NUM_Z           = 3,
   parameter int MAX_Z           = 81,
   parameter int Z_VALUES [NUM_Z] = '{27, 54, 81},
   parameter int NUM_INFO_BLKS   = 20,
   parameter int NUM_PARITY_BLKS = 4,
   parameter int SHW             = $clog2(MAX_Z),
   parameter int ROM_AW          = $clog2(NUM_Z*NUM_INFO_BLKS)
) (
   input  logic                           CLK,
   input  logic                           rst,
   input  logic [NUM_Z-1:0]               req_z,
   input  logic [MAX_Z-1:0]               s_data,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic                           abort,
   output logic [ROM_AW-1:0]              rom_addr,
   input  logic [NUM_PARITY_BLKS*SHW-1:0] rom_data,
   output logic [MAX_Z-1:0]               m_data,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic                           m_last,
   output logic                           busy,
   output logic                           cfg_err,
   output logic                           shift_err
);

   localparam int ZIW = (NUM_Z > 1) ? $clog2(NUM_Z) : 1;
   localparam int CW  = $clog2(NUM_INFO_BLKS + 1);
   localparam int OW  = (NUM_PARITY_BLKS > 1) ? $clog2(NUM_PARITY_BLKS) : 1;

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} encState_t;

   encState_t         state;
   encState_t         nextState;
   logic [ZIW-1:0]    zIdx;
   logic [ZIW-1:0]    reqIdx;
   logic [ZIW-1:0]    beatIdx;
   logic              reqOneHot;
   int                beatZ;
   int                romCnt;
   logic [MAX_Z-1:0]  zMask;
   logic [MAX_Z-1:0]  beatData;
   logic [MAX_Z-1:0]  contrib [NUM_PARITY_BLKS];
   logic              beatErr;
   logic              accept;
   logic              mFire;
   logic [CW-1:0]     cnt;
   logic [OW-1:0]     oIdx;
   logic [MAX_Z-1:0]  acc [NUM_PARITY_BLKS];
   logic              cfgErrQ;
   logic              shiftErrQ;

   // Turn the one-hot Z request into a table index; the last set bit wins,
   // which only matters for illegal requests that are never accepted anyway.
   always_comb begin
      reqIdx    = '0;
      reqOneHot = $onehot(req_z);
      for (int k = 0; k < NUM_Z; k++) begin
         if (req_z[k]) begin
            reqIdx = ZIW'(k);
         end
      end
   end

   // Work out the contribution of the current info beat to every parity
   // block. The first beat of a frame still uses the live request because
   // zIdx is only latched on that same edge. Rotation inside a Z-bit ring is
   // a left shift OR'd with the bits that wrap past Z, masked back to Z bits.
   // A null shift adds nothing; an out-of-range shift adds nothing and flags.
   always_comb begin
      beatIdx = (state == IDLE) ? reqIdx : zIdx;
      beatZ   = MAX_Z;
      if (int'(beatIdx) < NUM_Z) begin
         beatZ = Z_VALUES[beatIdx];
      end
      zMask    = {MAX_Z{1'b1}} >> (MAX_Z - beatZ);
      beatData = s_data & zMask;
      beatErr  = 1'b0;
      for (int j = 0; j < NUM_PARITY_BLKS; j++) begin
         contrib[j] = '0;
         if (rom_data[j*SHW +: SHW] != {SHW{1'b1}}) begin
            if (int'(rom_data[j*SHW +: SHW]) >= beatZ) begin
               beatErr = 1'b1;
            end else begin
               contrib[j] = ((beatData << int'(rom_data[j*SHW +: SHW])) |
                             (beatData >> (beatZ - int'(rom_data[j*SHW +: SHW])))) & zMask;
            end
         end
      end
   end

   // ROM address and handshake qualifiers. s_ready is dropped while abort is
   // high so an upstream sender never believes a discarded beat was taken.
   always_comb begin
      romCnt   = (state == IDLE) ? 0 : int'(cnt);
      rom_addr = ROM_AW'(int'(beatIdx) * NUM_INFO_BLKS + romCnt);
      s_ready  = 1'b0;
      if (!rst && !abort) begin
         if (state == IDLE) begin
            s_ready = reqOneHot;
         end else if (state == ACCUM) begin
            s_ready = 1'b1;
         end
      end
      accept = s_valid && s_ready;
      mFire  = (state == DRAIN) && m_ready && !abort;
   end

   // Frame sequencing: collect NUM_INFO_BLKS beats, drain the parity blocks,
   // return to idle. Abort overrides everything.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (accept) begin
               nextState = (NUM_INFO_BLKS == 1) ? DRAIN : ACCUM;
            end
         end
         ACCUM: begin
            if (accept && (int'(cnt) == NUM_INFO_BLKS - 1)) begin
               nextState = DRAIN;
            end
         end
         DRAIN: begin
            if (mFire && (int'(oIdx) == NUM_PARITY_BLKS - 1)) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
      if (abort) begin
         nextState = IDLE;
      end
   end

   // State register.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Accumulators, counters, latched Z and the error flags. The first beat
   // overwrites the accumulators so no residue from a previous frame can
   // leak in; later beats XOR in. shift_err restarts with each frame.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         zIdx      <= '0;
         cnt       <= '0;
         oIdx      <= '0;
         cfgErrQ   <= 1'b0;
         shiftErrQ <= 1'b0;
         for (int j = 0; j < NUM_PARITY_BLKS; j++) begin
            acc[j] <= '0;
         end
      end else begin
         cfgErrQ <= (state == IDLE) && s_valid && !reqOneHot && !abort;
         if (abort) begin
            cnt  <= '0;
            oIdx <= '0;
            for (int j = 0; j < NUM_PARITY_BLKS; j++) begin
               acc[j] <= '0;
            end
         end else begin
            if (accept) begin
               if (state == IDLE) begin
                  zIdx      <= reqIdx;
                  cnt       <= CW'(1);
                  shiftErrQ <= beatErr;
                  for (int j = 0; j < NUM_PARITY_BLKS; j++) begin
                     acc[j] <= contrib[j];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
                  if (beatErr) begin
                     shiftErrQ <= 1'b1;
                  end
                  for (int j = 0; j < NUM_PARITY_BLKS; j++) begin
                     acc[j] <= acc[j] ^ contrib[j];
                  end
               end
            end
            if (mFire) begin
               oIdx <= (int'(oIdx) == NUM_PARITY_BLKS - 1) ? '0 : oIdx + 1'b1;
            end
         end
      end
   end

   // Output port view of the registered state; everything reads zero
   // outside DRAIN so a reset mid-frame shows no partial parity.
   always_comb begin
      m_valid   = (state == DRAIN);
      m_last    = (state == DRAIN) && (int'(oIdx) == NUM_PARITY_BLKS - 1);
      m_data    = (state == DRAIN) ? acc[oIdx] : '0;
      busy      = (state != IDLE);
      cfg_err   = cfgErrQ;
      shift_err = shiftErrQ;
   end

endmodule

// File: doc/qcldpc_stream_encoder.md
# qcldpc_stream_encoder

Multi-Z streaming QC-LDPC parity encoder: accepts one Z-bit information block per cycle over a valid/ready handshake and accumulates every parity block in parallel from cyclically shifted info blocks. It then drains the NUM_PARITY_BLKS parity blocks over a second valid/ready port. It sits between the info-data buffer and the codeword assembler. It replaces the single-rate encoder datapath with run-time Z selection, handshaking, abort and error reporting. Circulant shifts come from an external proto-matrix ROM through a combinational read port.

## Interface
- NUM_Z, 3, number of supported lifting sizes
- MAX_Z, 81, largest Z; width of all data ports
- Z_VALUES[NUM_Z], {27,54,81}, lifting sizes; req_z bit k selects Z_VALUES[k]
- NUM_INFO_BLKS, 20, info blocks per codeword
- NUM_PARITY_BLKS, 4, parity blocks per codeword
- SHW, $clog2(MAX_Z), width of one shift value; all-ones value = null circulant
- ROM_AW, $clog2(NUM_Z*NUM_INFO_BLKS), ROM address width
- CLK  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_z  in  NUM_Z  one-hot Z select, sampled on first accepted beat
- s_data  in  MAX_Z  info block; bits ≥ Z ignored
- s_valid  in  1  info block valid
- s_ready  out  1  info block accepted when s_valid&&s_ready
- abort  in  1  synchronous frame abort
- rom_addr  out  ROM_AW  = zidx*NUM_INFO_BLKS + info index
- rom_data  in  NUM_PARITY_BLKS*SHW  shift for parity j at [j*SHW +: SHW], same-cycle valid
- m_data  out  MAX_Z  parity block; bits ≥ Z are 0
- m_valid  out  1  parity valid
- m_ready  in  1  parity consumer ready
- m_last  out  1  marks parity block NUM_PARITY_BLKS-1
- busy  out  1  state ≠ IDLE
- cfg_err  out  1  one-cycle pulse, invalid req_z on attempted start
- shift_err  out  1  sticky until next frame start: shift ≥ Z and not null

## Operation
- States: IDLE, ACCUM, DRAIN.
- IDLE:
  - s_ready = $onehot(req_z).
  - rom_addr uses the index of req_z and info index 0.
  - On acceptance: latch zidx, clear shift_err, then write (not XOR) acc[j] = rot(s_data, sh[j]) for all j.
  - After the first acceptance: cnt=1 and go to ACCUM, or to DRAIN if NUM_INFO_BLKS==1.
  - s_valid with a non-one-hot req_z: no acceptance, cfg_err pulses next cycle, stay IDLE.
- ACCUM:
  - s_ready=1 and rom_addr = zidx*NUM_INFO_BLKS + cnt.
  - On each accepted beat: acc[j] ^= rot(s_data, sh[j]) and cnt++.
  - After the accept that makes cnt==NUM_INFO_BLKS, go to DRAIN with out index 0.
- rot(x,s): out[(k+s) mod Z] = x[k] for k<Z; out bits ≥ Z = 0.
- Null shift (all ones) contributes zero.
- A shift in range Z..2^SHW-2 contributes zero and sets shift_err.
- DRAIN:
  - s_ready=0, m_valid=1, m_data=acc[oidx], m_last=(oidx==NUM_PARITY_BLKS-1).
  - On m_valid&&m_ready: oidx++; after the last block go to IDLE.
  - m_data is held stable while m_ready is low.
- abort (any state) forces IDLE next cycle, clears cnt, oidx and m_valid, and discards acc. It has priority over a same-cycle accept or handshake.
- req_z changes after frame start are ignored until IDLE.

## Timing
- Reset values:
  - state=IDLE, s_ready=0 (forced while rst high), m_valid=0, m_last=0, m_data=0, busy=0, cfg_err=0, shift_err=0, acc=0.
- Throughput: one info block per cycle with s_valid held high; no bubbles in ACCUM.
- Latency: last info beat accepted at edge t → m_valid=1 from cycle t+1.
- Drain takes NUM_PARITY_BLKS cycles with m_ready=1; the next frame may be accepted the cycle after the final output handshake.
- Frame period with full throughput = NUM_INFO_BLKS + NUM_PARITY_BLKS cycles.
- The ROM read is combinational within the accept cycle; the only registers are acc, counters, state, zidx and the flags.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous); no partial parity is emitted.

## Test plan
- Z=27 (req_z=001), info_i = 1<<i for i=0..19, shifts p0 all 0, p1–p3 null → p0 = 0x00FFFFF, p1..p3 = 0, m_last on the 4th output, first m_valid one cycle after the 20th accept.
- Z=54 wrap: info0 bit 53 set, other info 0, p0 shift 1, p1 shift 53 → p0 = bit 0 only, p1 = bit 52 only, bits 54–80 zero.
- Backpressure: m_ready low for 5 cycles during DRAIN → m_data/m_last stable, s_ready=0, no beats lost; s_valid gaps during ACCUM produce the same parity as the gapless frame.
- req_z=011 with s_valid=1 → s_ready=0, cfg_err one-cycle pulse, state stays IDLE; then req_z=100 → frame accepted normally.
- abort after 7 accepted beats → IDLE next cycle; the following full Z=81 frame yields parity equal to a golden model (no residue from the aborted frame).
- ROM returns shift 30 with Z=27 → shift_err=1, block contributes zero; rst asserted mid-DRAIN → m_valid=0 and busy=0 immediately.
